i2c_write_engine: RTL and testbench
===================================

Name: i2c_write_engine

Overview:
- Byte-serial I2C master that performs one 3-byte write: slave address, sub-address, data.
- Sits directly downstream of the audio/video codec configuration sequencer and consumes its 24-bit command word and GO/END/ACK handshake.
- Drives the shared I2C_SCLK/I2C_SDAT pins of the board codecs.
- Runs on the system clock with an internal quarter-bit tick, so no derived clock domain is needed.

Parameters:
- CLK_FREQ, 50000000: iCLK frequency in Hz.
- I2C_FREQ, 20000: SCL frequency in Hz.
- Q (localparam), CLK_FREQ/(4*I2C_FREQ): iCLK cycles per quarter-bit. Legal only when Q >= 3.

Ports:
- iCLK  in  1  system clock
- iRST_N  in  1  asynchronous active-low reset
- iDATA  in  24  command word {slave_addr[7:0], sub_addr[7:0], data[7:0]}; bit 23 is sent first
- iGO  in  1  level request; a transfer starts when iGO is high in IDLE
- oEND  out  1  transfer complete; held high until iGO goes low
- oACK  out  1  1 = at least one byte was NACKed; 0 = all three ACKed; valid while oEND=1
- oBUSY  out  1  high from acceptance until oEND rises
- I2C_SCLK  out  1  SCL, push-pull
- I2C_SDAT  inout  1  SDA, open-drain: drives 0 or Z only, never 1

Behaviour:
- Reset: iRST_N is asynchronous, active-low; the clock is iCLK.
  - Reset values: I2C_SCLK=1, I2C_SDAT=Z, oEND=0, oACK=0, oBUSY=0, state=IDLE, tick counter=0.
  - Reset mid-transfer forces these values at once; no STOP is generated.
- Tick: a counter runs 0..Q-1 while not in IDLE/DONE and is cleared on acceptance. Each wrap ends one quarter; the state/phase advances on that edge.
- Acceptance: in IDLE with iGO=1, the engine latches iDATA into the shift register, sets oBUSY=1, clears oACK, and enters START_A on the same edge. Later iDATA changes are ignored.
- Quarters, with (SCL, SDA) shown:
  - START_A (1,0)
  - START_B (0,0)
  - 27 bits, each 4 quarters q0..q3:
    - q0: SCL=0; SDA = the data bit, or Z for the 9th (ACK) bit of each byte.
    - q1: SCL=1.
    - q2: SCL=1.
    - q3: SCL=0.
  - STOP_A (0,0)
  - STOP_B (1,0)
  - STOP_C (1,Z)
  - then DONE.
  - Total: 113 quarters.
- ACK sampling: I2C_SDAT goes through a 2-flop synchronizer. It is sampled on the last iCLK cycle of q2 of each ACK bit. A sample of 1 sets sticky oACK.
- NACK handling: the transfer is never aborted. All bytes and the STOP are always sent; the upstream sequencer retries on oACK=1.
- Latency: oEND and oACK become valid exactly 113*Q cycles after the acceptance edge. oBUSY falls on the same edge.
- DONE state:
  - oEND stays 1 while iGO=1, and no retransmission occurs.
  - On iGO=0, oEND clears on the next edge and the engine returns to IDLE.
  - oACK holds its value until the next acceptance.
  - A new transfer requires iGO to go low, then high again.
- iGO dropping mid-transfer is ignored; the transfer completes.
- Bit order: MSB first within each byte, bytes in the order 23:16, 15:8, 7:0.

Test Plan:
- Reset: assert iRST_N=0 mid-byte (Q=5) -> in the same cycle I2C_SCLK=1, I2C_SDAT=Z, oBUSY=0, oEND=0. After release, the engine stays in IDLE while iGO=0.
- Full write: iDATA=24'h34001A, iGO=1, slave model ACKs every byte, Q=5 -> bits captured on SCL rising edges decode as 0x34, 0x00, 0x1A. START and STOP are seen on the bus. oEND=1 and oACK=0 exactly 565 cycles after acceptance.
- NACK: iDATA=24'h40C301, slave NACKs the second byte only -> all 27 bits and the STOP are still sent; oACK=1 with oEND.
- Handshake: hold iGO=1 for 50 cycles after oEND -> no SCL activity and oEND stays 1. Drop iGO -> oEND=0 next cycle. Reassert iGO with 24'h341201 -> new transfer carries 0x12, 0x01.
- Data stability: change iDATA to 24'hFFFFFF one quarter after acceptance of 24'h340C00 -> the bus still carries 0x34, 0x0C, 0x00.
- Open-drain check over all scenarios: the testbench asserts I2C_SDAT never drives 1. SDA changes only while SCL=0, except in START_A and STOP_C.

Source files
------------

// File: rtl/i2c_write_engine.sv
// Byte-serial I2C master: sends {slave_addr, sub_addr, data} as one write, paced by a quarter-bit tick.
// SCL is push-pull; SDA is open-drain and is sampled through a 2-flop synchronizer for ACK.
//
// state   | meaning
// IDLE    | waiting for iGO; SCL=1, SDA released
// START_A | SCL=1, SDA=0 (start condition)
// START_B | SCL=0, SDA=0
// BITS    | 27 bit slots (3 x 8 data + ACK), four quarters each
// STOP_A  | SCL=0, SDA=0
// STOP_B  | SCL=1, SDA=0
// STOP_C  | SCL=1, SDA released (stop condition)
// DONE    | oEND held until iGO drops
module i2c_write_engine #(
    parameter int CLK_FREQ = 50000000,
    parameter int I2C_FREQ = 20000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [23:0] iDATA,
    input  logic        iGO,
    output logic        oEND,
    output logic        oACK,
    output logic        oBUSY,
    output logic        I2C_SCLK,
    inout  wire         I2C_SDAT
);
    localparam int Q  = CLK_FREQ / (4 * I2C_FREQ);
    localparam int TW = (Q > 1) ? $clog2(Q) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(Q - 1);

    typedef enum logic [2:0] {
        IDLE, START_A, START_B, BITS, STOP_A, STOP_B, STOP_C, DONE
    } state_t;

    state_t        state, stateNext;
    logic [TW-1:0] tick, tickNext;
    logic [1:0]    quarter, quarterNext;
    logic [3:0]    bitIdx, bitIdxNext;
    logic [1:0]    byteIdx, byteIdxNext;
    logic [23:0]   shiftReg, shiftNext;
    logic          ackReg, ackNext;
    logic          sclQ, sclNext;
    logic          sdaLowQ, sdaLowNext;
    logic          endQ, busyQ;
    logic [1:0]    sdaSync;
    logic          wrap;

    assign wrap = (tick == TICK_LAST);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state    <= IDLE;
            tick     <= '0;
            quarter  <= '0;
            bitIdx   <= '0;
            byteIdx  <= '0;
            shiftReg <= '0;
            ackReg   <= 1'b0;
            sclQ     <= 1'b1;
            sdaLowQ  <= 1'b0;
            endQ     <= 1'b0;
            busyQ    <= 1'b0;
            sdaSync  <= 2'b11;
        end else begin
            state    <= stateNext;
            tick     <= tickNext;
            quarter  <= quarterNext;
            bitIdx   <= bitIdxNext;
            byteIdx  <= byteIdxNext;
            shiftReg <= shiftNext;
            ackReg   <= ackNext;
            sclQ     <= sclNext;
            sdaLowQ  <= sdaLowNext;
            endQ     <= (stateNext == DONE);
            busyQ    <= (stateNext != IDLE) && (stateNext != DONE);
            sdaSync  <= {sdaSync[0], I2C_SDAT};
        end
    end

    always_comb begin
        stateNext   = state;
        tickNext    = '0;
        quarterNext = quarter;
        bitIdxNext  = bitIdx;
        byteIdxNext = byteIdx;
        shiftNext   = shiftReg;
        ackNext     = ackReg;
        if (state != IDLE && state != DONE)
            tickNext = wrap ? '0 : tick + TW'(1);

        case (state)
            IDLE: begin
                if (iGO) begin
                    stateNext   = START_A;
                    shiftNext   = iDATA;
                    ackNext     = 1'b0;
                    quarterNext = '0;
                    bitIdxNext  = '0;
                    byteIdxNext = '0;
                end
            end
            START_A: if (wrap) stateNext = START_B;
            START_B: begin
                if (wrap) begin
                    stateNext   = BITS;
                    quarterNext = '0;
                    bitIdxNext  = '0;
                    byteIdxNext = '0;
                end
            end
            BITS: begin
                // ACK slot is sampled on the last cycle of its q2, while SCL is high
                if (wrap && quarter == 2'd2 && bitIdx == 4'd8 && sdaSync[1])
                    ackNext = 1'b1;
                if (wrap) begin
                    quarterNext = quarter + 2'd1;
                    if (quarter == 2'd3) begin
                        if (bitIdx == 4'd8) begin
                            bitIdxNext = '0;
                            if (byteIdx == 2'd2)
                                stateNext = STOP_A;
                            else
                                byteIdxNext = byteIdx + 2'd1;
                        end else begin
                            bitIdxNext = bitIdx + 4'd1;
                            shiftNext  = {shiftReg[22:0], 1'b0};
                        end
                    end
                end
            end
            STOP_A:  if (wrap) stateNext = STOP_B;
            STOP_B:  if (wrap) stateNext = STOP_C;
            STOP_C:  if (wrap) stateNext = DONE;
            DONE:    if (!iGO) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase

        // Pin levels are decoded from the next state so they register on the same edge
        sclNext    = 1'b1;
        sdaLowNext = 1'b0;
        case (stateNext)
            START_A: sdaLowNext = 1'b1;
            START_B: begin sclNext = 1'b0; sdaLowNext = 1'b1; end
            BITS: begin
                sclNext    = (quarterNext == 2'd1) || (quarterNext == 2'd2);
                sdaLowNext = (bitIdxNext != 4'd8) && !shiftNext[23];
            end
            STOP_A:  begin sclNext = 1'b0; sdaLowNext = 1'b1; end
            STOP_B:  sdaLowNext = 1'b1;
            default: begin sclNext = 1'b1; sdaLowNext = 1'b0; end
        endcase
    end

    assign I2C_SCLK = sclQ;
    assign I2C_SDAT = sdaLowQ ? 1'b0 : 1'bz;
    assign oEND     = endQ;
    assign oACK     = ackReg;
    assign oBUSY    = busyQ;
endmodule

// File: tb/tb_i2c_write_engine.sv
// Randomized self-checking bench for i2c_write_engine with a bus monitor and an ACK/NACK slave model.
module tb_i2c_write_engine;
    localparam int Q   = 5;
    localparam int LAT = 113 * Q;

    logic        clk = 1'b0;
    logic        rstN;
    logic [23:0] data;
    logic        go;
    logic        oEND, oACK, oBUSY, scl;
    wire         sda;
    logic        slaveLow = 1'b0;
    logic [2:0]  nackMask = 3'b000;

    int checks = 0;
    int failures = 0;

    pullup (sda);
    assign sda = slaveLow ? 1'b0 : 1'bz;

    i2c_write_engine #(.CLK_FREQ(100000), .I2C_FREQ(5000)) dut (
        .iCLK(clk), .iRST_N(rstN), .iDATA(data), .iGO(go),
        .oEND(oEND), .oACK(oACK), .oBUSY(oBUSY),
        .I2C_SCLK(scl), .I2C_SDAT(sda)
    );

    always #5 clk = ~clk;

    task automatic chkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor + slave: captures bits on SCL rise, detects START/STOP, drives ACK per nackMask
    logic bitsQ[$];
    int   startCnt = 0, stopCnt = 0, violations = 0, riseCnt = 0, sclEdges = 0;
    bit   inXfer = 0;
    logic prevScl = 1'b1, prevSda = 1'b1;

    always @(negedge clk) begin
        logic c, s;
        c = scl;
        s = (sda === 1'b0) ? 1'b0 : 1'b1;
        if (!rstN) begin
            inXfer   = 0;
            slaveLow = 1'b0;
        end else begin
            if (c !== prevScl) sclEdges++;
            if (slaveLow && s) violations++;
            if (prevScl && c && s != prevSda) begin
                if (!s) begin
                    if (inXfer) violations++;
                    inXfer  = 1;
                    riseCnt = 0;
                    bitsQ.delete();
                    startCnt++;
                end else begin
                    if (!inXfer || riseCnt != 28) violations++;
                    inXfer = 0;
                    stopCnt++;
                end
            end else if (inXfer) begin
                if (!prevScl && c) begin
                    bitsQ.push_back(s);
                    riseCnt++;
                end
                if (prevScl && !c && riseCnt > 0) begin
                    if (riseCnt % 9 == 8)      slaveLow = !nackMask[riseCnt / 9];
                    else if (riseCnt % 9 == 0) slaveLow = 1'b0;
                end
            end
        end
        prevScl = c;
        prevSda = s;
    end

    task automatic runXfer(input logic [23:0] d, input logic [2:0] nm,
                           input bit chgData, input bit dropGo, input bit holdGo);
        int k, s0, p0, v0;
        bit gotEnd;
        logic busyPre;
        logic [26:0] expBits, gotBits;
        @(negedge clk);
        nackMask = nm; data = d; go = 1'b1;
        s0 = startCnt; p0 = stopCnt; v0 = violations;
        @(posedge clk); #1;
        chkVal("busyAccept", oBUSY, 1);
        k = 0; gotEnd = 0; busyPre = 1'b0;
        while (!gotEnd && k < 4 * LAT) begin
            @(posedge clk); #1;
            k++;
            if (chgData && k == Q) data = 24'hFFFFFF;
            if (dropGo && k == 100) go = 1'b0;
            if (k == LAT - 1) busyPre = oBUSY;
            if (oEND) gotEnd = 1;
        end
        chkVal("endLatency", k, LAT);
        chkVal("busyBeforeEnd", busyPre, 1);
        chkVal("busyAtEnd", oBUSY, 0);
        chkVal("ackFlag", oACK, {31'b0, |nm});
        expBits = '0;
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 8; i++) expBits = {expBits[25:0], d[23 - 8*b - i]};
            expBits = {expBits[25:0], nm[b]};
        end
        gotBits = '0;
        for (int i = 0; i < 27; i++)
            gotBits = {gotBits[25:0], (i < bitsQ.size()) ? bitsQ[i] : 1'bx};
        chkVal("nBits", bitsQ.size(), 28);
        chkVal("busBits", {5'b0, gotBits}, {5'b0, expBits});
        chkVal("startSeen", startCnt - s0, 1);
        chkVal("stopSeen", stopCnt - p0, 1);
        chkVal("busRules", violations - v0, 0);
        if (!holdGo) begin
            go = 1'b0;
            @(posedge clk); #1;
            chkVal("endClear", oEND, 0);
        end
    endtask

    initial begin
        int e0, hi;
        rstN = 1'b0; go = 1'b0; data = '0;
        repeat (3) @(posedge clk);
        #1;
        chkVal("rstScl", scl, 1);
        chkVal("rstSda", (sda === 1'b0) ? 0 : 1, 1);
        chkVal("rstEnd", oEND, 0);
        chkVal("rstAck", oACK, 0);
        chkVal("rstBusy", oBUSY, 0);
        @(negedge clk) rstN = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chkVal("idleBusy", oBUSY, 0);

        // Full write, then hold iGO in DONE, then re-arm
        runXfer(24'h34001A, 3'b000, 0, 0, 1);
        e0 = sclEdges; hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (oEND) hi++;
        end
        chkVal("holdEnd", hi, 50);
        chkVal("holdQuiet", sclEdges - e0, 0);
        go = 1'b0;
        @(posedge clk); #1;
        chkVal("dropEnd", oEND, 0);
        runXfer(24'h341201, 3'b000, 0, 0, 0);

        runXfer(24'h40C301, 3'b010, 0, 0, 0);
        runXfer(24'h340C00, 3'b000, 1, 0, 0);

        for (int n = 0; n < 6; n++)
            runXfer(24'($urandom), 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                    bit'($urandom_range(0, 1)), 0);

        // Reset in the middle of the second byte
        @(negedge clk);
        nackMask = 3'b000; data = 24'h340000; go = 1'b1;
        @(posedge clk);
        repeat (200) @(posedge clk);
        #2;
        rstN = 1'b0; go = 1'b0;
        #1;
        chkVal("midRstScl", scl, 1);
        chkVal("midRstSda", (sda === 1'b0) ? 0 : 1, 1);
        chkVal("midRstBusy", oBUSY, 0);
        chkVal("midRstEnd", oEND, 0);
        @(negedge clk) rstN = 1'b1;
        e0 = sclEdges;
        repeat (20) @(posedge clk);
        #1;
        chkVal("postRstBusy", oBUSY, 0);
        chkVal("postRstQuiet", sclEdges - e0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
